// File: rtl/alu_control_if.sv
// ---------------------------------------------------------------------------
// alu_control_if
//   Bundle between the main decoder (master) and the ALU control decoder
//   (slave).
//   Hold    : master -> slave, stall; registered outputs keep their value
//   ALUOp   : master -> slave, operation class (00 ld/st, 01 br, 10 R, 11 I)
//   Funct   : master -> slave, R-type function field
//   OPCode  : master -> slave, I-type opcode
//   ALUCtrl : slave -> master, registered ALU operation select
//   Illegal : slave -> master, registered undefined-encoding flag
// ---------------------------------------------------------------------------
interface alu_control_if;
    logic       Hold;
    logic [1:0] ALUOp;
    logic [3:0] Funct;
    logic [2:0] OPCode;
    logic [3:0] ALUCtrl;
    logic       Illegal;

    modport master (
        output Hold, ALUOp, Funct, OPCode,
        input  ALUCtrl, Illegal
    );

    modport slave (
        input  Hold, ALUOp, Funct, OPCode,
        output ALUCtrl, Illegal
    );
endinterface

// File: rtl/alu_control.sv
// ---------------------------------------------------------------------------
// alu_control
//   Registered ALU control decoder for the 16-bit single-issue CPU.
//   Decodes ALUOp / Funct / OPCode into a 4-bit ALU select one cycle later
//   and flags undefined Funct/OPCode encodings.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (ALUCtrl=ADD, Illegal=0)
//   bus   : alu_control_if.slave (Hold, ALUOp, Funct, OPCode in;
//           ALUCtrl, Illegal out)
// ---------------------------------------------------------------------------
module alu_control (
    input  logic          clk,
    input  logic          rst_n,
    alu_control_if.slave  bus
);

    // ALU operation select encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    // ALUOp classes
    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } dec_t;

    dec_t dec_d;
    dec_t dec_q;

    // Each field is only examined inside the branch that owns it, so an
    // X/Z on an ignored field never reaches the result. Plain case (not
    // casez/casex) sends an X selector to the default arm, which yields
    // ADD instead of propagating X.
    always_comb begin
        dec_d.ctrl    = ALU_ADD;
        dec_d.illegal = 1'b0;
        case (bus.ALUOp)
            OP_MEM: dec_d.ctrl = ALU_ADD;
            OP_BR:  dec_d.ctrl = ALU_SUB;
            OP_R: begin
                case (bus.Funct)
                    4'b0000: dec_d.ctrl = ALU_ADD;
                    4'b0001: dec_d.ctrl = ALU_SUB;
                    4'b0010: dec_d.ctrl = ALU_AND;
                    4'b0011: dec_d.ctrl = ALU_OR;
                    4'b0100: dec_d.ctrl = ALU_SLT;
                    4'b0101: dec_d.ctrl = ALU_SLL;
                    4'b0110: dec_d.ctrl = ALU_SRL;
                    4'b0111: dec_d.ctrl = ALU_SRA;
                    4'b1000: dec_d.ctrl = ALU_NOR;
                    4'b1101: dec_d.ctrl = ALU_XOR;
                    default: begin
                        dec_d.ctrl    = ALU_ADD;
                        dec_d.illegal = 1'b1;
                    end
                endcase
            end
            OP_I: begin
                case (bus.OPCode)
                    3'b001:  dec_d.ctrl = ALU_AND;
                    3'b010:  dec_d.ctrl = ALU_OR;
                    3'b011:  dec_d.ctrl = ALU_ADD;
                    3'b100:  dec_d.ctrl = ALU_SLT;
                    3'b101:  dec_d.ctrl = ALU_XOR;
                    default: begin
                        dec_d.ctrl    = ALU_ADD;
                        dec_d.illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_d.ctrl    = ALU_ADD;
                dec_d.illegal = 1'b0;
            end
        endcase
    end

    // Reset wins over Hold; Hold freezes both output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q.ctrl    <= ALU_ADD;
            dec_q.illegal <= 1'b0;
        end else if (!bus.Hold) begin
            dec_q <= dec_d;
        end
    end

    assign bus.ALUCtrl = dec_q.ctrl;
    assign bus.Illegal = dec_q.illegal;

endmodule

// File: tb/tb_alu_control.sv
// ---------------------------------------------------------------------------
// tb_alu_control
//   Directed-vector bench for alu_control. Expected {ALUCtrl, Illegal}
//   values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_control;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_control_if bus ();

    alu_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {ALUCtrl, Illegal} against the expected value; !== so X fails.
    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ctrl=%b ill=%b, want ctrl=%b ill=%b",
                     tag, got[4:1], got[0], exp[4:1], exp[0]);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.ALUCtrl, bus.Illegal};
    endfunction

    // Drive inputs on the falling edge, then sample 1 time unit after the
    // next rising edge.
    task automatic step(input logic hold, input logic [1:0] op,
                        input logic [3:0] f, input logic [2:0] oc);
        @(negedge clk);
        bus.Hold   = hold;
        bus.ALUOp  = op;
        bus.Funct  = f;
        bus.OPCode = oc;
        @(posedge clk);
        #1;
    endtask

    // R-type vectors: Funct -> expected {ctrl, illegal}
    logic [3:0] r_f   [7] = '{4'b0000, 4'b0001, 4'b1101, 4'b0010, 4'b1000, 4'b0111, 4'b1111};
    logic [4:0] r_exp [7] = '{5'b0010_0, 5'b0110_0, 5'b0011_0, 5'b0000_0,
                              5'b0100_0, 5'b1001_0, 5'b0010_1};
    // I-type vectors: OPCode -> expected {ctrl, illegal}
    logic [2:0] i_oc  [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b000};
    logic [4:0] i_exp [7] = '{5'b0000_0, 5'b0001_0, 5'b0010_0, 5'b0111_0,
                              5'b0011_0, 5'b0010_1, 5'b0010_1};

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b1;
        bus.Hold   = 1'b0;
        bus.ALUOp  = 2'b10;
        bus.Funct  = 4'b1111;
        bus.OPCode = 3'b000;

        // Async reset between edges, no edge needed.
        #2 rst_n = 1'b0;
        #1 chk("reset_async", outs(), 5'b0010_0);
        repeat (2) @(posedge clk);
        #1 chk("reset_held", outs(), 5'b0010_0);
        @(negedge clk);
        rst_n = 1'b1;

        // Class decode with ignored fields at X.
        step(1'b0, 2'b00, 4'bxxxx, 3'bxxx);
        chk("mem_add", outs(), 5'b0010_0);
        step(1'b0, 2'b01, 4'bxxxx, 3'bxxx);
        chk("br_sub", outs(), 5'b0110_0);

        // R-type sweep.
        foreach (r_f[k]) begin
            step(1'b0, 2'b10, r_f[k], 3'bxxx);
            chk($sformatf("rtype_%b", r_f[k]), outs(), r_exp[k]);
        end

        // I-type sweep.
        foreach (i_oc[k]) begin
            step(1'b0, 2'b11, 4'bxxxx, i_oc[k]);
            chk($sformatf("itype_%b", i_oc[k]), outs(), i_exp[k]);
        end

        // Latency: new inputs must not show before the edge, then must show.
        step(1'b0, 2'b10, 4'b0101, 3'b000);
        chk("lat_sll", outs(), 5'b0101_0);
        @(negedge clk);
        bus.ALUOp = 2'b10;
        bus.Funct = 4'b0110;
        #1 chk("lat_pre_edge", outs(), 5'b0101_0);
        @(posedge clk);
        #1 chk("lat_srl", outs(), 5'b1000_0);
        step(1'b0, 2'b10, 4'b0011, 3'b000);
        chk("lat_or", outs(), 5'b0001_0);

        // Hold: load SUB, then freeze for 3 edges with XOR presented.
        step(1'b0, 2'b01, 4'b0000, 3'b000);
        chk("hold_load_sub", outs(), 5'b0110_0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b10, 4'b1101, 3'b000);
            chk($sformatf("hold_edge%0d", k), outs(), 5'b0110_0);
        end
        step(1'b0, 2'b10, 4'b1101, 3'b000);
        chk("hold_release_xor", outs(), 5'b0011_0);

        // Hold keeps Illegal too.
        step(1'b0, 2'b10, 4'b1110, 3'b000);
        chk("illegal_load", outs(), 5'b0010_1);
        step(1'b1, 2'b00, 4'b0000, 3'b000);
        chk("illegal_held", outs(), 5'b0010_1);

        // Async reset mid-hold, discarding the held XOR.
        step(1'b0, 2'b10, 4'b1101, 3'b000);
        chk("pre_rst_xor", outs(), 5'b0011_0);
        step(1'b1, 2'b10, 4'b1111, 3'b000);
        chk("pre_rst_hold", outs(), 5'b0011_0);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_hold", outs(), 5'b0010_0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post_rst_hold", outs(), 5'b0010_0);
        step(1'b0, 2'b10, 4'b1111, 3'b000);
        chk("post_rst_load", outs(), 5'b0010_1);
        step(1'b0, 2'b11, 4'b0000, 3'b101);
        chk("post_rst_xori", outs(), 5'b0011_0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
